// File: rtl/slice_add_sequencer_pkg.sv
// Shared definitions for the bit-serial slice adder sequencer:
// FSM state encodings and default geometry.
package slice_add_sequencer_pkg;

    localparam int unsigned DefaultWidth = 32;
    localparam int unsigned DefaultSlice = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/select_adder.sv
// COUNT-bit carry-select adder: both carry-in cases are precomputed and
// the incoming carry picks one.
module select_adder #(
    parameter int unsigned COUNT = 4
) (
    input  logic [COUNT-1:0] a_i,
    input  logic [COUNT-1:0] b_i,
    input  logic             cin_i,
    output logic [COUNT-1:0] sum_o,
    output logic             cout_o
);

    logic [COUNT:0] sum_c0;
    logic [COUNT:0] sum_c1;

    always_comb begin
        sum_c0 = {1'b0, a_i} + {1'b0, b_i};
        sum_c1 = {1'b0, a_i} + {1'b0, b_i} + {{COUNT{1'b0}}, 1'b1};
        {cout_o, sum_o} = cin_i ? sum_c1 : sum_c0;
    end

endmodule

// File: rtl/slice_add_sequencer.sv
// Full-width adder built from one shared SLICE-bit adder, stepping through
// the operand one slice per cycle with a valid/ready handshake on each side.
module slice_add_sequencer
    import slice_add_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned SLICE = DefaultSlice
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned NSlice  = WIDTH / SLICE;
    localparam int unsigned IdxW    = (NSlice > 1) ? $clog2(NSlice) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NSlice - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;

    logic [SLICE-1:0]  slice_a;
    logic [SLICE-1:0]  slice_b;
    logic [SLICE-1:0]  slice_sum;
    logic              slice_cout;

    assign slice_a = a_q[idx_q*SLICE +: SLICE];
    assign slice_b = b_q[idx_q*SLICE +: SLICE];

    select_adder #(
        .COUNT (SLICE)
    ) u_select_adder (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[idx_q*SLICE +: SLICE] = slice_sum;
                carry_d                     = slice_cout;
                if (idx_q == LastIdx) begin
                    cout_d  = slice_cout;
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Operand registers also clear on reset so an aborted request leaves no trace.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
